// File: rtl/emesh_arb_if.sv
// emesh_arb_if: registered core<->mesh emesh interface.
// Egress routes core packets to one of N mesh channels by an index field.
// Ingress merges N mesh channels to the core with a round-robin arbiter.
// Ports:
//   clk, nreset                      clock, async active-low reset
//   emesh_access_in/packet_in        core egress packet in
//   emesh_ready_out                  egress register can accept
//   mesh_access_out/packet_out       per-channel egress out (all slices carry the same packet)
//   mesh_ready_in                    per-channel downstream ready
//   mesh_access_in/packet_in         per-channel ingress packets in
//   mesh_ready_out                   per-channel ingress grant
//   emesh_access_out/packet_out      merged packet to core
//   emesh_ready_in                   core ready
module emesh_arb_if #(
  parameter int AW   = 32,
  parameter int PW   = 2*AW+40,
  parameter int N    = 3,
  parameter int IW   = 2,
  parameter int ILSB = 0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            emesh_access_in,
  input  logic [PW-1:0]   emesh_packet_in,
  output logic            emesh_ready_out,
  output logic [N-1:0]    mesh_access_out,
  output logic [N*PW-1:0] mesh_packet_out,
  input  logic [N-1:0]    mesh_ready_in,
  input  logic [N-1:0]    mesh_access_in,
  input  logic [N*PW-1:0] mesh_packet_in,
  output logic [N-1:0]    mesh_ready_out,
  output logic            emesh_access_out,
  output logic [PW-1:0]   emesh_packet_out,
  input  logic            emesh_ready_in
);
  localparam logic [IW-1:0] NMAX = IW'(N-1);
  localparam logic [IW:0]   NW   = (IW+1)'(N);
  logic          eg_v_q, eg_v_d, eg_load;
  logic [PW-1:0] eg_p_q, eg_p_d;
  logic [IW-1:0] eg_d_q, eg_d_d, dst;
  logic          in_v_q, in_v_d, hit, le;
  logic [PW-1:0] in_p_q, in_p_d, sel_p;
  logic [IW-1:0] ptr_q, ptr_d, gi, j;
  logic [IW:0]   s;
  logic [N-1:0]  g;
  // Out-of-range indices fold onto the last channel.
  assign dst             = emesh_packet_in[ILSB +: IW] > NMAX ? NMAX : emesh_packet_in[ILSB +: IW];
  assign emesh_ready_out = ~eg_v_q | mesh_ready_in[eg_d_q];
  assign eg_load         = emesh_access_in & emesh_ready_out;
  assign eg_v_d          = eg_load | (eg_v_q & ~mesh_ready_in[eg_d_q]);
  assign eg_p_d          = eg_load ? emesh_packet_in : eg_p_q;
  assign eg_d_d          = eg_load ? dst : eg_d_q;
  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    assign mesh_access_out[i]          = eg_v_q & (eg_d_q == IW'(i));
    assign mesh_packet_out[i*PW +: PW] = eg_p_q;
  end
  // Search channels starting at ptr, wrapping modulo N; first requester wins.
  always_comb begin
    g     = '0;
    gi    = '0;
    hit   = 1'b0;
    s     = '0;
    j     = '0;
    sel_p = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr_q} + (IW+1)'(k);
      s = s >= NW ? s - NW : s;
      j = s[IW-1:0];
      if (!hit && mesh_access_in[j]) begin
        hit  = 1'b1;
        g[j] = 1'b1;
        gi   = j;
      end
    end
    for (int c = 0; c < N; c++)
      if (g[c]) sel_p = mesh_packet_in[c*PW +: PW];
  end
  assign le               = ~in_v_q | emesh_ready_in;
  assign mesh_ready_out   = {N{le}} & g;
  assign in_v_d           = le ? hit : in_v_q;
  assign in_p_d           = le & hit ? sel_p : in_p_q;
  assign ptr_d            = le & hit ? (gi == NMAX ? '0 : gi + 1'b1) : ptr_q;
  assign emesh_access_out = in_v_q;
  assign emesh_packet_out = in_p_q;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      eg_v_q <= 1'b0;
      eg_p_q <= '0;
      eg_d_q <= '0;
      in_v_q <= 1'b0;
      in_p_q <= '0;
      ptr_q  <= '0;
    end else begin
      eg_v_q <= eg_v_d;
      eg_p_q <= eg_p_d;
      eg_d_q <= eg_d_d;
      in_v_q <= in_v_d;
      in_p_q <= in_p_d;
      ptr_q  <= ptr_d;
    end
endmodule

// File: tb/tb_emesh_arb_if.sv
// tb_emesh_arb_if: directed vector table, reset sequence and random concurrent traffic for emesh_arb_if
module tb_emesh_arb_if;
  localparam int AW = 32;
  localparam int PW = 2*AW+40;
  localparam int N  = 3;
  logic            clk = 1'b0;
  logic            nreset;
  logic            emesh_access_in;
  logic [PW-1:0]   emesh_packet_in;
  logic            emesh_ready_out;
  logic [N-1:0]    mesh_access_out;
  logic [N*PW-1:0] mesh_packet_out;
  logic [N-1:0]    mesh_ready_in;
  logic [N-1:0]    mesh_access_in;
  logic [N*PW-1:0] mesh_packet_in;
  logic [N-1:0]    mesh_ready_out;
  logic            emesh_access_out;
  logic [PW-1:0]   emesh_packet_out;
  logic            emesh_ready_in;
  emesh_arb_if #(.AW(AW), .N(N), .IW(2), .ILSB(0)) dut (
    .clk(clk), .nreset(nreset),
    .emesh_access_in(emesh_access_in), .emesh_packet_in(emesh_packet_in), .emesh_ready_out(emesh_ready_out),
    .mesh_access_out(mesh_access_out), .mesh_packet_out(mesh_packet_out), .mesh_ready_in(mesh_ready_in),
    .mesh_access_in(mesh_access_in), .mesh_packet_in(mesh_packet_in), .mesh_ready_out(mesh_ready_out),
    .emesh_access_out(emesh_access_out), .emesh_packet_out(emesh_packet_out), .emesh_ready_in(emesh_ready_in)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       e_acc;
    logic [7:0] e_pk;
    logic [2:0] mrdy;
    logic [2:0] macc;
    logic       erdy;
    logic       x_ero;
    logic [2:0] x_mao;
    logic [7:0] x_mp;
    logic [2:0] x_mro;
    logic       x_eao;
    logic [7:0] x_ep;
  } vec_t;
  typedef struct packed {
    logic [1:0]    d;
    logic [PW-1:0] p;
  } eg_t;
  vec_t tv[$];
  eg_t  egq[$];
  eg_t  f;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  int e_sent, e_got, i_got, ch, idx;
  int i_sent[3];
  int rx_seq[3];
  int ilim[3];
  logic       e_fire;
  logic [2:0] i_fire;
  initial begin
    nreset = 1'b0; emesh_access_in = 1'b0; emesh_packet_in = '0; mesh_ready_in = '0;
    mesh_access_in = '0; mesh_packet_in = '0; emesh_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ero", emesh_ready_out, 1);
    chk("rst_mao", mesh_access_out, 0);
    chk("rst_eao", emesh_access_out, 0);
    chk("rst_mro", mesh_ready_out, 0);
    chk("rst_mp", mesh_packet_out, 0);
    chk("rst_ep", emesh_packet_out, 0);
    nreset = 1'b1;
    for (int c = 0; c < N; c++) mesh_packet_in[c*PW +: PW] = PW'(8'hC0 + c);
    // egress routing, clamping, backpressure (channel 1 stalled 5 cycles), drain+load
    tv.push_back(vec_t'{1'b1, 8'h10, 3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 8'h00, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h21, 3'b111, 3'b000, 1'b1, 1'b1, 3'b001, 8'h10, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h32, 3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 8'h21, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h43, 3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 8'h32, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 8'h43, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h55, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 8'h43, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h64, 3'b101, 3'b000, 1'b1, 1'b0, 3'b010, 8'h55, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h64, 3'b001, 3'b000, 1'b1, 1'b0, 3'b010, 8'h55, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h64, 3'b100, 3'b000, 1'b1, 1'b0, 3'b010, 8'h55, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h64, 3'b000, 3'b000, 1'b1, 1'b0, 3'b010, 8'h55, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h64, 3'b101, 3'b000, 1'b1, 1'b0, 3'b010, 8'h55, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b1, 8'h64, 3'b010, 3'b000, 1'b1, 1'b1, 3'b010, 8'h55, 3'b000, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b000, 1'b1, 1'b1, 3'b001, 8'h64, 3'b000, 1'b0, 8'h00});
    // ingress round robin, stall, skip to channel 2 with wrap, le with in_v=0
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 8'h64, 3'b001, 1'b0, 8'h00});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 8'h64, 3'b010, 1'b1, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 8'h64, 3'b100, 1'b1, 8'hC1});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 8'h64, 3'b001, 1'b1, 8'hC2});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 8'h64, 3'b010, 1'b1, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 8'h64, 3'b100, 1'b1, 8'hC1});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 8'h64, 3'b001, 1'b1, 8'hC2});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 8'h64, 3'b000, 1'b1, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 8'h64, 3'b000, 1'b1, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 8'h64, 3'b000, 1'b1, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b100, 1'b1, 1'b1, 3'b000, 8'h64, 3'b100, 1'b1, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b011, 1'b1, 1'b1, 3'b000, 8'h64, 3'b001, 1'b1, 8'hC2});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 8'h64, 3'b000, 1'b1, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 8'h64, 3'b000, 1'b0, 8'hC0});
    tv.push_back(vec_t'{1'b0, 8'h00, 3'b111, 3'b110, 1'b0, 1'b1, 3'b000, 8'h64, 3'b010, 1'b0, 8'hC0});
    for (int k = 0; k < tv.size(); k++) begin
      emesh_access_in = tv[k].e_acc;
      emesh_packet_in = PW'(tv[k].e_pk);
      mesh_ready_in   = tv[k].mrdy;
      mesh_access_in  = tv[k].macc;
      emesh_ready_in  = tv[k].erdy;
      @(negedge clk);
      chk($sformatf("row%0d_ero", k), emesh_ready_out, tv[k].x_ero);
      chk($sformatf("row%0d_mao", k), mesh_access_out, tv[k].x_mao);
      for (int c = 0; c < N; c++)
        chk($sformatf("row%0d_mp%0d", k, c), mesh_packet_out[c*PW +: PW], PW'(tv[k].x_mp));
      chk($sformatf("row%0d_mro", k), mesh_ready_out, tv[k].x_mro);
      chk($sformatf("row%0d_eao", k), emesh_access_out, tv[k].x_eao);
      chk($sformatf("row%0d_ep", k), emesh_packet_out, PW'(tv[k].x_ep));
      @(posedge clk);
      #1;
    end
    // asynchronous reset mid-stream with both registers valid (ptr=2, in_p=C1)
    emesh_access_in = 1'b1; emesh_packet_in = PW'(8'h7A); mesh_ready_in = 3'b000;
    mesh_access_in = 3'b000; emesh_ready_in = 1'b0;
    @(posedge clk);
    #1;
    emesh_access_in = 1'b0;
    chk("pre_rst_mao", mesh_access_out, 3'b100);
    chk("pre_rst_eao", emesh_access_out, 1);
    chk("pre_rst_ep", emesh_packet_out, PW'(8'hC1));
    mesh_access_in = 3'b110;
    #2 nreset = 1'b0;
    #1;
    chk("arst_mao", mesh_access_out, 0);
    chk("arst_eao", emesh_access_out, 0);
    chk("arst_mp", mesh_packet_out, 0);
    chk("arst_ep", emesh_packet_out, 0);
    chk("arst_ero", emesh_ready_out, 1);
    chk("arst_mro", mesh_ready_out, 3'b010);
    @(negedge clk);
    nreset = 1'b1; mesh_access_in = 3'b101; emesh_ready_in = 1'b1;
    #1;
    chk("post_rst_mro", mesh_ready_out, 3'b001);
    @(posedge clk);
    #1;
    chk("post_rst_eao", emesh_access_out, 1);
    chk("post_rst_ep", emesh_packet_out, PW'(8'hC0));
    mesh_access_in = 3'b000;
    @(posedge clk);
    #1;
    // random concurrent traffic in both directions
    e_sent = 0; e_got = 0; i_got = 0;
    ilim[0] = 34; ilim[1] = 33; ilim[2] = 33;
    for (int c = 0; c < 3; c++) begin i_sent[c] = 0; rx_seq[c] = 0; end
    for (int cyc = 0; cyc < 4000 && !(e_got == 100 && i_got == 100); cyc++) begin
      if (!emesh_access_in && e_sent < 100) begin
        idx = $urandom_range(0, 3);
        emesh_packet_in = PW'({32'($urandom), 14'(e_sent), 2'(idx)});
        emesh_access_in = 1'b1;
      end
      for (int c = 0; c < N; c++)
        if (!mesh_access_in[c] && i_sent[c] < ilim[c] && $urandom_range(0, 3) != 0) begin
          mesh_packet_in[c*PW +: PW] = PW'({8'(c + 1), 8'(i_sent[c])});
          mesh_access_in[c] = 1'b1;
        end
      mesh_ready_in  = 3'($urandom);
      emesh_ready_in = $urandom_range(0, 3) != 0;
      @(negedge clk);
      e_fire = 1'b0;
      i_fire = '0;
      for (int c = 0; c < N; c++)
        if (mesh_access_out[c] && mesh_ready_in[c]) begin
          if (egq.size() == 0) chk("eg_spurious", mesh_access_out, 0);
          else begin
            f = egq.pop_front();
            chk("eg_dest", c, f.d);
            chk("eg_pkt", mesh_packet_out[c*PW +: PW], f.p);
            e_got++;
          end
        end
      if (emesh_access_in && emesh_ready_out) begin
        f.p = emesh_packet_in;
        f.d = emesh_packet_in[1:0] == 2'd3 ? 2'd2 : emesh_packet_in[1:0];
        egq.push_back(f);
        e_fire = 1'b1;
        e_sent++;
      end
      for (int c = 0; c < N; c++)
        if (mesh_access_in[c] && mesh_ready_out[c]) begin
          i_fire[c] = 1'b1;
          i_sent[c]++;
        end
      if (emesh_access_out && emesh_ready_in) begin
        ch = int'(emesh_packet_out[15:8]) - 1;
        chk("in_chan_ok", ch >= 0 && ch < 3, 1);
        if (ch >= 0 && ch < 3) begin
          chk("in_seq", emesh_packet_out[7:0], 8'(rx_seq[ch]));
          rx_seq[ch]++;
        end
        i_got++;
      end
      @(posedge clk);
      #1;
      if (e_fire) emesh_access_in = 1'b0;
      for (int c = 0; c < N; c++) if (i_fire[c]) mesh_access_in[c] = 1'b0;
    end
    chk("eg_total", e_got, 100);
    chk("in_total", i_got, 100);
    chk("eg_queue_empty", egq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
